// File: rtl/phy_rx_serial_aligner_if.sv
// Serial-in / aligned-byte-out bundle between the bit sampler and the downstream demux.
interface phy_rx_serial_aligner_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_strobe,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_strobe,
        output active
    );
endinterface

// File: rtl/phy_rx_serial_aligner.sv
// Serial-to-parallel receiver: finds byte alignment on a comma symbol, locks after
// BC_COUNT consecutive aligned commas, then emits one byte per 8 bit clocks.
module phy_rx_serial_aligner #(
    parameter logic [7:0] COMMA    = 8'hBC,
    parameter int          BC_COUNT = 4
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    phy_rx_serial_aligner_if.slave bus
);

    typedef enum logic [1:0] {
        SEARCH,
        LOCKING,
        ALIGNED
    } state_t;

    localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

    state_t     state;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [3:0] bc_cnt;
    logic [7:0] data_q;
    logic       valid_q;
    logic       strobe_q;
    logic       active_q;

    logic [7:0] w;
    logic       is_comma;
    logic       boundary;
    logic       lock_done;

    // w is the byte completed by the bit being sampled on this edge.
    assign w         = {sr[6:0], bus.data_in};
    assign is_comma  = (w == COMMA);
    assign boundary  = (bit_cnt == 3'd7);
    assign lock_done = ((bc_cnt + 4'd1) == BC_TARGET);

    // NOTE: all state and outputs are registered with non-blocking assignments so
    // every branch reads the pre-edge values of sr, bit_cnt and bc_cnt.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state    <= SEARCH;
            sr       <= 8'h00;
            bit_cnt  <= 3'd0;
            bc_cnt   <= 4'd0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            sr       <= w;
            strobe_q <= 1'b0;

            case (state)
                SEARCH: begin
                    if (is_comma) begin
                        bit_cnt <= 3'd0;
                        bc_cnt  <= 4'd1;
                        if (BC_COUNT == 1) begin
                            state    <= ALIGNED;
                            active_q <= 1'b1;
                        end else begin
                            state <= LOCKING;
                        end
                    end
                end

                LOCKING: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (is_comma) begin
                            bc_cnt <= bc_cnt + 4'd1;
                            if (lock_done) begin
                                state    <= ALIGNED;
                                active_q <= 1'b1;
                            end
                        end else begin
                            bc_cnt <= 4'd0;
                            state  <= SEARCH;
                        end
                    end
                end

                ALIGNED: begin
                    // Lock is sticky; only reset returns to SEARCH.
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        data_q   <= w;
                        valid_q  <= !is_comma;
                        strobe_q <= 1'b1;
                    end
                end

                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

    assign bus.data_out    = data_q;
    assign bus.valid_out   = valid_q;
    assign bus.byte_strobe = strobe_q;
    assign bus.active      = active_q;

endmodule

// File: tb/tb_phy_rx_serial_aligner.sv
// Self-checking bench for phy_rx_serial_aligner: table-driven serial stimulus with a
// byte scoreboard checked by a per-cycle output monitor.
module tb_phy_rx_serial_aligner;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;

    phy_rx_serial_aligner_if bus ();

    phy_rx_serial_aligner #(
        .COMMA   (8'hBC),
        .BC_COUNT(4)
    ) dut (
        .clk_32f(clk_32f),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct {
        logic        do_reset;
        int          nbits;
        logic [15:0] pattern;
        logic        exp_out;
        logic        exp_valid;
        logic        exp_active;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       valid;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic rst, input int nb, input logic [15:0] pat,
                                input logic eo, input logic ev, input logic ea);
        vec_t v;
        v.do_reset   = rst;
        v.nbits      = nb;
        v.pattern    = pat;
        v.exp_out    = eo;
        v.exp_valid  = ev;
        v.exp_active = ea;
        vecs.push_back(v);
    endfunction

    task automatic send_bit(input logic b);
        bus.data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] pat, input int nb);
        for (int i = nb - 1; i >= 0; i--) send_bit(pat[i]);
    endtask

    task automatic do_reset(input int cycles);
        reset       = 1'b1;
        bus.data_in = 1'b0;
        repeat (cycles) begin
            @(posedge clk_32f);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic v);
        exp_t e;
        e.data  = d;
        e.valid = v;
        exp_q.push_back(e);
    endtask

    // Output monitor: samples 1 time unit after every rising edge.
    int         cyc         = 0;
    int         last_strobe = -1;
    logic [7:0] hold_data   = 8'h00;
    logic       hold_valid  = 1'b0;

    always begin
        logic rst_s;
        exp_t e;
        @(posedge clk_32f);
        rst_s = reset;
        #1;
        cyc++;
        if (rst_s) begin
            check("reset_outputs",
                  {22'd0, bus.data_out, bus.valid_out, bus.byte_strobe, bus.active}, 32'd0);
            last_strobe = -1;
            hold_data   = 8'h00;
            hold_valid  = 1'b0;
        end else if (bus.byte_strobe) begin
            check("strobe_while_active", 32'(bus.active), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'(bus.data_out), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("data_out", 32'(bus.data_out), 32'(e.data));
                check("valid_out", 32'(bus.valid_out), 32'(e.valid));
                hold_data  = e.data;
                hold_valid = e.valid;
            end
            if (last_strobe >= 0) check("strobe_spacing", 32'(cyc - last_strobe), 32'd8);
            last_strobe = cyc;
        end else begin
            check("hold_data_out", 32'(bus.data_out), 32'(hold_data));
            check("hold_valid_out", 32'(bus.valid_out), 32'(hold_valid));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_in = 1'b0;

        // Lock, two data bytes, then an idle comma and one more data byte.
        add(1, 0, 16'h0, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 1);
        add(0, 8, 16'hFF, 1, 1, 1);
        add(0, 8, 16'hEE, 1, 1, 1);
        add(0, 8, 16'hBC, 1, 0, 1);
        add(0, 8, 16'hAB, 1, 1, 1);
        // Three-bit offset ahead of the commas.
        add(1, 0, 16'h0, 0, 0, 0);
        add(0, 3, 16'h0, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 1);
        add(0, 8, 16'h5A, 1, 1, 1);
        // Broken comma run: count restarts at 1 with the comma after 0x00.
        add(1, 0, 16'h0, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'h00, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 1);
        add(0, 8, 16'hC3, 1, 1, 1);
        // Comma straddling a byte edge, followed by a non-comma: back to SEARCH.
        add(1, 0, 16'h0, 0, 0, 0);
        add(0, 8, 16'h5E, 0, 0, 0);
        add(0, 8, 16'h00, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 1);
        add(0, 8, 16'h5E, 1, 1, 1);
        // Straddling comma counted as the first of the run at the unaligned phase.
        add(1, 0, 16'h0, 0, 0, 0);
        add(0, 9, 16'h0BC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 0);
        add(0, 8, 16'hBC, 0, 0, 1);
        add(0, 8, 16'hC3, 1, 1, 1);

        foreach (vecs[k]) begin
            if (vecs[k].do_reset) begin
                do_reset(3);
                check($sformatf("v%0d_active_after_reset", k), 32'(bus.active), 32'd0);
            end else begin
                if (vecs[k].exp_out) expect_byte(vecs[k].pattern[7:0], vecs[k].exp_valid);
                send_bits(vecs[k].pattern, vecs[k].nbits);
                check($sformatf("v%0d_active", k), 32'(bus.active), 32'(vecs[k].exp_active));
            end
        end

        // Reset on bit 4 of a byte while locked, then a full relock is required.
        do_reset(3);
        repeat (3) send_bits(16'hBC, 8);
        check("mid_reset_pre_lock", 32'(bus.active), 32'd0);
        send_bits(16'hBC, 8);
        check("mid_reset_locked", 32'(bus.active), 32'd1);
        expect_byte(8'h77, 1'b1);
        send_bits(16'h77, 8);
        check("mid_reset_byte_77", 32'(bus.data_out), 32'h77);
        send_bits(16'h7, 3);
        reset = 1'b1;
        send_bit(1'b1);
        reset = 1'b0;
        check("mid_reset_data_out", 32'(bus.data_out), 32'h0);
        check("mid_reset_valid_out", 32'(bus.valid_out), 32'd0);
        check("mid_reset_strobe", 32'(bus.byte_strobe), 32'd0);
        check("mid_reset_active", 32'(bus.active), 32'd0);
        send_bits(16'hF, 4);
        repeat (3) send_bits(16'hBC, 8);
        check("relock_not_yet", 32'(bus.active), 32'd0);
        send_bits(16'hBC, 8);
        check("relock_done", 32'(bus.active), 32'd1);
        expect_byte(8'h33, 1'b1);
        send_bits(16'h33, 8);

        repeat (2) send_bit(1'b0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
